// File: rtl/execution_pipeline_buffer.sv
// execution_pipeline_buffer
//
// EX->MEM pipeline stage built as a DEPTH-entry elastic FIFO with a
// valid/ready handshake on both sides. A push that carries a data-cache
// access raises a lock that refuses further pushes until the data cache
// pulses unlock. A synchronous flush empties the buffer and drops the lock
// so a branch redirect can restart the stage cleanly.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake
//   in_instruction, in_extended_immediate, in_alu_result, in_second_input,
//   in_destination_register, in_ctrl
//                              entry fields; in_ctrl bit 2 = d_cache_access
//   flush                      discard all entries and clear the lock
//   unlock                     one-cycle data-cache completion pulse
//   out_valid / out_ready      downstream handshake on the head entry
//   out_*                      head entry fields, read from storage
//   count                      number of occupied entries
//   locked                     memory-access lock active
module execution_pipeline_buffer #(
    parameter int WORD_WIDTH           = 32,
    parameter int REGISTER_INDEX_WIDTH = 5,
    parameter int DEPTH                = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WORD_WIDTH-1:0]           in_instruction,
    input  logic [WORD_WIDTH-1:0]           in_extended_immediate,
    input  logic [WORD_WIDTH-1:0]           in_alu_result,
    input  logic [WORD_WIDTH-1:0]           in_second_input,
    input  logic [REGISTER_INDEX_WIDTH-1:0] in_destination_register,
    input  logic [5:0]                      in_ctrl,
    input  logic                            flush,
    input  logic                            unlock,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WORD_WIDTH-1:0]           out_instruction,
    output logic [WORD_WIDTH-1:0]           out_extended_immediate,
    output logic [WORD_WIDTH-1:0]           out_alu_result,
    output logic [WORD_WIDTH-1:0]           out_second_input,
    output logic [REGISTER_INDEX_WIDTH-1:0] out_destination_register,
    output logic [5:0]                      out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            locked
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = 4*WORD_WIDTH + REGISTER_INDEX_WIDTH + 6;

    typedef enum logic {
        LOCK_OPEN,
        LOCK_HELD
    } lock_state_t;

    logic [ENTRY_W-1:0] entry_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    lock_state_t        lock_state_reg, lock_state_next;

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_entry;

    assign locked    = (lock_state_reg == LOCK_HELD);
    assign count     = count_reg;
    assign out_valid = (count_reg != '0);

    // No pass-through when full: a pop only frees a slot for the next cycle.
    assign in_ready  = (count_reg < CNT_W'(DEPTH)) & ~locked & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~flush;

    assign in_entry = {in_instruction, in_extended_immediate, in_alu_result,
                       in_second_input, in_destination_register, in_ctrl};

    // Head is always taken from storage, never bypassed from the inputs.
    assign head_entry = entry_mem[rd_ptr_reg];
    assign {out_instruction, out_extended_immediate, out_alu_result,
            out_second_input, out_destination_register, out_ctrl} = head_entry;

    // Entry storage: each slot is written whole and then left untouched
    // until it has been popped and reused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_mem[i] <= '0;
            end
        end else if (push) begin
            entry_mem[wr_ptr_reg] <= in_entry;
        end
    end

    // Pointer and occupancy next-state; flush overrides any handshake.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Lock FSM next-state. A push can only happen while open, so a
    // simultaneous unlock in the open state has nothing to release.
    always_comb begin
        lock_state_next = lock_state_reg;
        if (flush) begin
            lock_state_next = LOCK_OPEN;
        end else begin
            case (lock_state_reg)
                LOCK_OPEN: begin
                    if (push && in_ctrl[2]) begin
                        lock_state_next = LOCK_HELD;
                    end
                end
                LOCK_HELD: begin
                    if (unlock) begin
                        lock_state_next = LOCK_OPEN;
                    end
                end
                default: lock_state_next = LOCK_OPEN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            lock_state_reg <= LOCK_OPEN;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            lock_state_reg <= lock_state_next;
        end
    end

endmodule

// File: tb/tb_execution_pipeline_buffer.sv
// Testbench for execution_pipeline_buffer (DEPTH=2). A reference model
// (queue of expected entries plus a lock flag) is updated on every cycle
// from the driven inputs; popped heads are compared against the queue.
module tb_execution_pipeline_buffer;

    localparam int W  = 32;
    localparam int R  = 5;
    localparam int D  = 2;
    localparam int CW = $clog2(D+1);

    typedef struct {
        logic [W-1:0] ins;
        logic [W-1:0] imm;
        logic [W-1:0] alu;
        logic [W-1:0] sec;
        logic [R-1:0] rd;
        logic [5:0]   ctrl;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_instruction = '0;
    logic [W-1:0]  in_extended_immediate = '0;
    logic [W-1:0]  in_alu_result = '0;
    logic [W-1:0]  in_second_input = '0;
    logic [R-1:0]  in_destination_register = '0;
    logic [5:0]    in_ctrl = '0;
    logic          flush = 1'b0;
    logic          unlock = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_instruction;
    logic [W-1:0]  out_extended_immediate;
    logic [W-1:0]  out_alu_result;
    logic [W-1:0]  out_second_input;
    logic [R-1:0]  out_destination_register;
    logic [5:0]    out_ctrl;
    logic [CW-1:0] count;
    logic          locked;

    int     checks = 0;
    int     errors = 0;
    entry_t sb_q[$];
    logic   m_locked = 1'b0;

    execution_pipeline_buffer #(.WORD_WIDTH(W), .REGISTER_INDEX_WIDTH(R), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_extended_immediate(in_extended_immediate),
        .in_alu_result(in_alu_result), .in_second_input(in_second_input),
        .in_destination_register(in_destination_register), .in_ctrl(in_ctrl),
        .flush(flush), .unlock(unlock),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_extended_immediate(out_extended_immediate),
        .out_alu_result(out_alu_result), .out_second_input(out_second_input),
        .out_destination_register(out_destination_register), .out_ctrl(out_ctrl),
        .count(count), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] alu, input logic [R-1:0] rd,
                         input logic [5:0] ctrl, input logic [W-1:0] sec);
        in_valid                = v;
        in_alu_result           = alu;
        in_instruction          = alu ^ 32'h1234_0000;
        in_extended_immediate   = ~alu;
        in_second_input         = sec;
        in_destination_register = rd;
        in_ctrl                 = ctrl;
    endtask

    // One clock cycle: check stable outputs against the model, update the
    // model with what the coming edge should do, then cross the edge.
    task automatic tick(input string tag);
        logic   exp_ready;
        logic   m_push;
        entry_t e;
        #2;
        exp_ready = (sb_q.size() < D) && !m_locked && !flush;
        chk({tag, ".in_ready"},  64'(in_ready),  64'(exp_ready));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(sb_q.size() != 0));
        chk({tag, ".count"},     64'(count),     64'(sb_q.size()));
        chk({tag, ".locked"},    64'(locked),    64'(m_locked));
        m_push = in_valid && exp_ready;
        if (flush) begin
            sb_q.delete();
            m_locked = 1'b0;
        end else begin
            if (sb_q.size() != 0 && out_ready) begin
                e = sb_q.pop_front();
                $display("POP  %s alu=%h rd=%0d ctrl=%b", tag, out_alu_result,
                         out_destination_register, out_ctrl);
                chk({tag, ".pop_alu"},  64'(out_alu_result),           64'(e.alu));
                chk({tag, ".pop_ins"},  64'(out_instruction),          64'(e.ins));
                chk({tag, ".pop_imm"},  64'(out_extended_immediate),   64'(e.imm));
                chk({tag, ".pop_sec"},  64'(out_second_input),         64'(e.sec));
                chk({tag, ".pop_rd"},   64'(out_destination_register), 64'(e.rd));
                chk({tag, ".pop_ctrl"}, 64'(out_ctrl),                 64'(e.ctrl));
            end
            if (m_push) begin
                e.ins = in_instruction; e.imm = in_extended_immediate;
                e.alu = in_alu_result;  e.sec = in_second_input;
                e.rd  = in_destination_register; e.ctrl = in_ctrl;
                sb_q.push_back(e);
                $display("PUSH %s alu=%h rd=%0d ctrl=%b", tag, in_alu_result,
                         in_destination_register, in_ctrl);
            end
            if (m_locked && unlock) m_locked = 1'b0;
            else if (!m_locked && m_push && in_ctrl[2]) m_locked = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".count"},     64'(count),          64'(0));
        chk({tag, ".out_valid"}, 64'(out_valid),      64'(0));
        chk({tag, ".locked"},    64'(locked),         64'(0));
        chk({tag, ".in_ready"},  64'(in_ready),       64'(1));
        chk({tag, ".out_alu"},   64'(out_alu_result), 64'(0));
        chk({tag, ".out_ins"},   64'(out_instruction),64'(0));
        chk({tag, ".out_ctrl"},  64'(out_ctrl),       64'(0));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Fill DEPTH=2 with out_ready=0, third op held, then drain in order
        drive(1, 32'h10, 5'd1, 6'b000010, 32'h0); tick("fill0");
        drive(1, 32'h20, 5'd2, 6'b000010, 32'h0); tick("fill1");
        drive(1, 32'h30, 5'd3, 6'b000010, 32'h0); tick("full_hold");
        out_ready = 1'b1;                          tick("drain0");
        tick("drain1");
        drive(0, 32'h0, 5'd0, 6'b0, 32'h0);        tick("drain2");
        tick("empty_pop");

        // Streaming with pointer wrap
        for (int i = 0; i < 8; i++) begin
            drive(1, W'(i), R'(i + 4), 6'b000010, 32'h0);
            tick("stream");
        end
        drive(0, 32'h0, 5'd0, 6'b0, 32'h0);        tick("stream_tail");

        // Load locks; held ALU op waits for unlock while the load drains
        drive(1, 32'h100, 5'd7, 6'b000101, 32'h0); tick("load_push");
        drive(1, 32'h200, 5'd8, 6'b000010, 32'h0);
        tick("locked0"); tick("locked1"); tick("locked2");
        unlock = 1'b1;                             tick("unlock");
        unlock = 1'b0;                             tick("after_unlock");
        drive(0, 32'h0, 5'd0, 6'b0, 32'h0);        tick("lock_tail");

        // Fill while locked, then flush with both handshakes active
        out_ready = 1'b0;
        drive(1, 32'h300, 5'd9, 6'b000010, 32'h0);  tick("pre_flush0");
        drive(1, 32'h400, 5'd10, 6'b000101, 32'h0); tick("pre_flush1");
        drive(1, 32'h500, 5'd11, 6'b000010, 32'h0);
        out_ready = 1'b1; flush = 1'b1;             tick("flush");
        flush = 1'b0; out_ready = 1'b0;
        drive(0, 32'h0, 5'd0, 6'b0, 32'h0);         tick("post_flush");

        // Asynchronous reset mid-operation while full and locked
        drive(1, 32'h600, 5'd12, 6'b000010, 32'h0); tick("pre_rst0");
        drive(1, 32'h700, 5'd13, 6'b000101, 32'h0); tick("pre_rst1");
        drive(0, 32'h0, 5'd0, 6'b0, 32'h0);
        chk("pre_rst.count", 64'(count), 64'(2));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        sb_q.delete();
        m_locked = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 32'hABCD, 5'd14, 6'b000010, 32'h0); tick("post_rst_push");
        drive(0, 32'h0, 5'd0, 6'b0, 32'h0);
        chk("post_rst.alu", 64'(out_alu_result), 64'(32'hABCD));
        out_ready = 1'b1;                            tick("post_rst_pop");
        out_ready = 1'b0;

        // Stray unlock while open with a simultaneous byte store push
        unlock = 1'b1;
        drive(1, 32'h800, 5'd15, 6'b011100, 32'hDEADBEEF); tick("store_push");
        unlock = 1'b0;
        drive(0, 32'h0, 5'd0, 6'b0, 32'h0);
        chk("store.sec",  64'(out_second_input), 64'(32'hDEADBEEF));
        chk("store.byte", 64'(out_ctrl[4]),      64'(1));
        out_ready = 1'b1;                            tick("store_pop");
        unlock = 1'b1;                               tick("store_unlock");
        unlock = 1'b0;                               tick("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
